// File: rtl/hlsm_sched_pkg.sv
// Shared types and sizing helpers for the HLSM job scheduler.
package hlsm_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ISSUE = 3'd2,
        BUSY  = 3'd3,
        RESP  = 3'd4
    } sched_state_e;

    localparam int DEFAULT_DW   = 32;
    localparam int DEFAULT_NREQ = 4;

    // Requester index width; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request after ptr, wrapping.
module rr_arbiter
    import hlsm_sched_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_valid
);

    logic [ID_W-1:0] cand;

    // Offsets 1..NREQ put the last winner at the very end of the search.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!any_valid && req[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = any_valid;
    end

endmodule

// File: rtl/hlsm_job_scheduler.sv
// Shares one Start/Done HLSM datapath among NREQ requesters with round-robin grants.
// Optional BUSY watchdog and rsp_err port enabled by defining HLSM_TIMEOUT_EN.
module hlsm_job_scheduler
    import hlsm_sched_pkg::*;
#(
    parameter int NREQ           = DEFAULT_NREQ,
    parameter int DW             = DEFAULT_DW,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DW-1:0]      req_a,
    input  logic [NREQ*DW-1:0]      req_b,
    input  logic [NREQ*DW-1:0]      req_c,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [id_w(NREQ)-1:0]   rsp_id,
    output logic [DW-1:0]           rsp_z,
    output logic [DW-1:0]           rsp_x,
`ifdef HLSM_TIMEOUT_EN
    output logic                    rsp_err,
`endif
    output logic                    dp_start,
    output logic [DW-1:0]           dp_a,
    output logic [DW-1:0]           dp_b,
    output logic [DW-1:0]           dp_c,
    input  logic                    dp_done,
    input  logic [DW-1:0]           dp_z,
    input  logic [DW-1:0]           dp_x,
    output logic                    busy
);

    localparam int ID_W = id_w(NREQ);

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [DW-1:0]   dp_a_q, dp_a_d;
    logic [DW-1:0]   dp_b_q, dp_b_d;
    logic [DW-1:0]   dp_c_q, dp_c_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_z_q, rsp_z_d;
    logic [DW-1:0]   rsp_x_q, rsp_x_d;

    logic [NREQ-1:0] arb_grant;
    logic [ID_W-1:0] arb_idx;
    logic            arb_any;
    logic [DW-1:0]   sel_a, sel_b, sel_c;

`ifdef HLSM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            rsp_err_q, rsp_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    assign sel_a = req_a[int'(arb_idx)*DW +: DW];
    assign sel_b = req_b[int'(arb_idx)*DW +: DW];
    assign sel_c = req_c[int'(arb_idx)*DW +: DW];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        dp_a_d    = dp_a_q;
        dp_b_d    = dp_b_q;
        dp_c_d    = dp_c_q;
        rsp_id_d  = rsp_id_q;
        rsp_z_d   = rsp_z_q;
        rsp_x_d   = rsp_x_q;
        req_ready = '0;
        dp_start  = 1'b0;
        rsp_valid = 1'b0;
`ifdef HLSM_TIMEOUT_EN
        wdog_d    = wdog_q;
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) state_d = ARB;
            end
            // Operands are captured only here, so they stay put for the whole job.
            ARB: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    dp_a_d    = sel_a;
                    dp_b_d    = sel_b;
                    dp_c_d    = sel_c;
                    owner_d   = arb_idx;
                    rr_ptr_d  = arb_idx;
`ifdef HLSM_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d   = ISSUE;
                end else begin
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                dp_start = 1'b1;
`ifdef HLSM_TIMEOUT_EN
                wdog_d   = '0;
`endif
                state_d  = BUSY;
            end
            BUSY: begin
                if (dp_done) begin
                    rsp_z_d  = dp_z;
                    rsp_x_d  = dp_x;
                    rsp_id_d = owner_q;
                    state_d  = RESP;
                end
`ifdef HLSM_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_z_d   = '0;
                    rsp_x_d   = '0;
                    rsp_id_d  = owner_q;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= ID_W'(NREQ - 1);
            owner_q   <= '0;
            dp_a_q    <= '0;
            dp_b_q    <= '0;
            dp_c_q    <= '0;
            rsp_id_q  <= '0;
            rsp_z_q   <= '0;
            rsp_x_q   <= '0;
`ifdef HLSM_TIMEOUT_EN
            wdog_q    <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            dp_a_q    <= dp_a_d;
            dp_b_q    <= dp_b_d;
            dp_c_q    <= dp_c_d;
            rsp_id_q  <= rsp_id_d;
            rsp_z_q   <= rsp_z_d;
            rsp_x_q   <= rsp_x_d;
`ifdef HLSM_TIMEOUT_EN
            wdog_q    <= wdog_d;
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    assign dp_a   = dp_a_q;
    assign dp_b   = dp_b_q;
    assign dp_c   = dp_c_q;
    assign rsp_id = rsp_id_q;
    assign rsp_z  = rsp_z_q;
    assign rsp_x  = rsp_x_q;
    assign busy   = (state_q != IDLE);
`ifdef HLSM_TIMEOUT_EN
    assign rsp_err = rsp_err_q;
`endif

endmodule

// File: tb/tb_hlsm_job_scheduler.sv
// Self-checking bench for hlsm_job_scheduler with a behavioural HLSM datapath model.
// Define HLSM_TIMEOUT_EN to also exercise the watchdog path.
module tb_hlsm_job_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;
`ifdef HLSM_TIMEOUT_EN
    localparam int TMO  = 8;
`else
    localparam int TMO  = 64;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] req_a, req_b, req_c;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_z, rsp_x;
`ifdef HLSM_TIMEOUT_EN
    logic              rsp_err;
`endif
    logic              dp_start;
    logic [DW-1:0]     dp_a, dp_b, dp_c;
    logic              dp_done = 1'b0;
    logic [DW-1:0]     dp_z = '0;
    logic [DW-1:0]     dp_x = '0;
    logic              busy;

    always #5 clk = ~clk;

    hlsm_job_scheduler #(
        .NREQ           (NREQ),
        .DW             (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk       (clk),
        .Rst       (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_x     (rsp_x),
`ifdef HLSM_TIMEOUT_EN
        .rsp_err   (rsp_err),
`endif
        .dp_start  (dp_start),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .dp_done   (dp_done),
        .dp_z      (dp_z),
        .dp_x      (dp_x),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int a;
        int b;
        int c;
        int exp_z;
        int exp_x;
    } vec_t;

    typedef struct {
        int id;
        int z;
        int x;
        bit err;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   dp_lat = 3;
    bit   dp_hang = 1'b0;
    int   dp_cnt = 0;
    logic [DW-1:0] lat_a, lat_b, lat_c;

    // Behaviour of the generated HLSM: branch on a<b.
    function automatic int hlsm_z(input int a, input int b, input int c);
        return (a < b) ? (b + c) * c : a * b + c;
    endfunction

    task automatic checkValue(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Datapath model runs on negedges and ignores scheduler reset, like the real integrator.
    always @(negedge clk) begin
        dp_done = 1'b0;
        if (dp_cnt > 0) begin
            dp_cnt = dp_cnt - 1;
            if (dp_cnt == 0 && !dp_hang) begin
                dp_done = 1'b1;
                dp_z = hlsm_z($signed(lat_a), $signed(lat_b), $signed(lat_c));
                dp_x = lat_a - lat_b;
                if (busy)
                    checkValue("dp_operands_held", longint'(dp_a == lat_a && dp_b == lat_b && dp_c == lat_c), 1);
            end
        end
        if (dp_start) begin
            lat_a  = dp_a;
            lat_b  = dp_b;
            lat_c  = dp_c;
            dp_cnt = dp_lat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input bit push);
        int id = vecs[k].id;
        req_valid[id]       = 1'b1;
        req_a[id*DW +: DW]  = vecs[k].a;
        req_b[id*DW +: DW]  = vecs[k].b;
        req_c[id*DW +: DW]  = vecs[k].c;
        if (push) sb.push_back('{id, vecs[k].exp_z, vecs[k].exp_x, 1'b0});
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: got response id %0d, expected none", rsp_id);
        end else begin
            e = sb.pop_front();
            checkValue("rsp_id", rsp_id, e.id);
            checkValue("rsp_z", $signed(rsp_z), e.z);
            checkValue("rsp_x", $signed(rsp_x), e.x);
`ifdef HLSM_TIMEOUT_EN
            checkValue("rsp_err", rsp_err, e.err);
`endif
        end
    endtask

    task automatic waitGrant(input int id, output int cycles);
        cycles = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cycles++;
            if (req_ready != '0) break;
        end
        checkValue("grant_onehot", req_ready, 1 << id);
    endtask

    task automatic waitRsp(output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cycles++;
            if (rsp_valid) break;
        end
        checkValue("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic finishJob();
        checkOutput();
        rsp_ready = 1'b1;
        tick();
        checkValue("rsp_valid_drop", rsp_valid, 0);
    endtask

    task automatic runJob(input int k);
        int id = vecs[k].id;
        int c;
        applyStimulus(k, 1'b1);
        waitGrant(id, c);
        checkValue("req_ready_latency", c, 1);
        tick();
        checkValue("dp_start_issue", dp_start, 1);
        checkValue("req_ready_single", req_ready, 0);
        checkValue("dp_a", $signed(dp_a), vecs[k].a);
        checkValue("dp_b", $signed(dp_b), vecs[k].b);
        checkValue("dp_c", $signed(dp_c), vecs[k].c);
`ifdef HLSM_TIMEOUT_EN
        checkValue("rsp_err_cleared", rsp_err, 0);
`endif
        req_valid[id] = 1'b0;
        tick();
        checkValue("dp_start_single", dp_start, 0);
        waitRsp(c);
        checkValue("rsp_latency", c, dp_lat);
        finishJob();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] aborting");
    end

    initial begin
        int c;
        int grants;
        int resps;
        bit stray_seen;
        logic [NREQ-1:0] prev_ready;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        vecs[0] = '{0,    3,    5,  2,   14,  -2};
        vecs[1] = '{1,    5,    3,  2,   17,   2};
        vecs[2] = '{2,   -4,    6,  3,   27, -10};
        vecs[3] = '{3,    7,   -2, -5,  -19,   9};
        vecs[4] = '{0,    0,    0,  9,    9,   0};
        vecs[5] = '{3, -100, -100, -1, 9999,   0};
        vecs[6] = '{2,    1,    2, -3,    3,  -1};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        checkValue("reset_busy", busy, 0);
        checkValue("reset_rsp_valid", rsp_valid, 0);
        checkValue("reset_req_ready", req_ready, 0);
        checkValue("reset_dp_start", dp_start, 0);
        checkValue("reset_dp_a", dp_a, 0);
        checkValue("reset_rsp_id", rsp_id, 0);
        checkValue("reset_rsp_z", rsp_z, 0);
`ifdef HLSM_TIMEOUT_EN
        checkValue("reset_rsp_err", rsp_err, 0);
`endif
        rst_n = 1'b1;
        tick();

        $display("[TB] table-driven single jobs");
        for (int k = 0; k < 7; k++) runJob(k);

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus(4, 1'b1);
        waitGrant(0, c);
        tick();
        req_valid[0] = 1'b0;
        applyStimulus(6, 1'b1);
        waitRsp(c);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkValue("stall_valid", rsp_valid, 1);
            checkValue("stall_z", $signed(rsp_z), vecs[4].exp_z);
            checkValue("stall_id", rsp_id, 0);
            checkValue("stall_no_grant", req_ready, 0);
        end
        finishJob();
        waitGrant(2, c);
        checkValue("grant_after_handshake", c, 1);
        tick();
        req_valid[2] = 1'b0;
        waitRsp(c);
        finishJob();

        $display("[TB] contention from reset");
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(k, 1'b0);
        for (int g = 0; g < 5; g++)
            sb.push_back('{exp_order[g], vecs[exp_order[g]].exp_z, vecs[exp_order[g]].exp_x, 1'b0});
        tick();
        rst_n = 1'b1;
        grants = 0;
        resps = 0;
        prev_ready = '0;
        for (int i = 0; i < 200 && resps < 5; i++) begin
            tick();
            if (req_ready != '0) begin
                if (grants < 5) checkValue("contention_grant", req_ready, 1 << exp_order[grants]);
                checkValue("ready_single_cycle", prev_ready, 0);
                grants++;
            end
            prev_ready = req_ready;
            if (rsp_valid) begin
                checkOutput();
                resps++;
                if (resps == 5) req_valid = '0;
            end
        end
        checkValue("contention_responses", resps, 5);
        checkValue("contention_grants", grants, 5);
        tick();

        $display("[TB] reset while busy");
        dp_lat = 8;
        applyStimulus(1, 1'b0);
        waitGrant(1, c);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        checkValue("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkValue("midreset_busy", busy, 0);
        checkValue("midreset_rsp_valid", rsp_valid, 0);
        checkValue("midreset_dp_a", dp_a, 0);
        checkValue("midreset_dp_b", dp_b, 0);
        checkValue("midreset_dp_c", dp_c, 0);
        checkValue("midreset_dp_start", dp_start, 0);
        checkValue("midreset_req_ready", req_ready, 0);
        stray_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dp_done) stray_seen = 1'b1;
            checkValue("no_rsp_after_reset", rsp_valid, 0);
        end
        checkValue("stray_done_seen", stray_seen, 1);
        checkValue("idle_after_stray_done", busy, 0);
        dp_lat = 3;

        // Pointer must be back at NREQ-1, so requester 0 wins over requester 2.
        applyStimulus(0, 1'b1);
        applyStimulus(6, 1'b1);
        waitGrant(0, c);
        tick();
        req_valid[0] = 1'b0;
        waitRsp(c);
        finishJob();
        waitGrant(2, c);
        tick();
        req_valid[2] = 1'b0;
        waitRsp(c);
        finishJob();

`ifdef HLSM_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        dp_hang = 1'b1;
        applyStimulus(2, 1'b0);
        sb.push_back('{2, 0, 0, 1'b1});
        waitGrant(2, c);
        tick();
        checkValue("timeout_dp_start", dp_start, 1);
        req_valid[2] = 1'b0;
        waitRsp(c);
        checkValue("timeout_latency", c, TMO + 1);
        finishJob();
        dp_hang = 1'b0;
        runJob(3);
`endif

        checkValue("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
